barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with four shift modes and a valid/ready handshake on both sides. It replaces single-mode combinational left shifters in the in-order superscalar CPU's FP normalise/align path and in the integer shift unit. A sideband tag travels with each operation so results can be matched to their destination.

---
 rtl/shift_pkg.sv | 11 +
 rtl/shift_level.sv | 48 ++++
 rtl/barrel_shift_pipe.sv | 196 +++++++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift mode encoding shared by the barrel shifter pipeline
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one logarithmic shift level (shift by DIST when en), sticky under SHIFT_STICKY_EN
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DIST  = 1
) (
    input  logic             en,
    input  shift_mode_e      mode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result
`ifdef SHIFT_STICKY_EN
    ,
    input  logic             sticky,
    output logic             sticky_next
`endif
);

    always_comb begin
        result = data;
        if (en) begin
            case (mode)
                SHIFT_SLL: result = data << DIST;
                SHIFT_SRL: result = data >> DIST;
                SHIFT_SRA: result = $signed(data) >>> DIST;
                default:   result = (data << DIST) | (data >> (WIDTH - DIST));
            endcase
        end
    end

`ifdef SHIFT_STICKY_EN
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - DIST);

    // Bits leaving past the MSB (SLL) or the LSB (SRL/SRA); rotation loses nothing.
    always_comb begin
        sticky_next = sticky;
        if (en) begin
            case (mode)
                SHIFT_SLL: sticky_next = sticky | (|(data >> (WIDTH - DIST)));
                SHIFT_SRL,
                SHIFT_SRA: sticky_next = sticky | (|(data & LOW_MASK));
                default:   sticky_next = sticky;
            endcase
        end
    end
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined 4-mode barrel shifter with valid/ready; sticky output under SHIFT_STICKY_EN
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int TAG_W   = 4,
    parameter int MID_REG = 0,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_STICKY_EN
    ,
    output logic             out_sticky
`endif
);

    localparam int SPLIT = SHW / 2;
    localparam logic [SHW:0] WIDTH_EXT = (SHW + 1)'(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        shift_mode_e      mode;
        logic [TAG_W-1:0] tag;
`ifdef SHIFT_STICKY_EN
        logic             sticky;
`endif
    } payload_t;

    payload_t         in_p;
    payload_t         s0_q;
    payload_t         tail;
    logic             s0_vld;
    logic             s0_load;
    logic             up_vld;
    logic             so_vld;
    logic             so_load;
    logic [WIDTH-1:0] so_data;
    logic [TAG_W-1:0] so_tag;
    logic             unused_tail;

    // Out-of-range amounts are resolved before S0 so the levels only ever see amounts below WIDTH.
    always_comb begin
        in_p.data = in_data;
        in_p.amt  = in_shamt;
        in_p.mode = shift_mode_e'(in_mode);
        in_p.tag  = in_tag;
`ifdef SHIFT_STICKY_EN
        in_p.sticky = 1'b0;
`endif
        if ({1'b0, in_shamt} >= WIDTH_EXT) begin
            if (in_p.mode == SHIFT_ROL) begin
                in_p.amt = SHW'({1'b0, in_shamt} - WIDTH_EXT);
            end else begin
                in_p.amt  = '0;
                in_p.data = (in_p.mode == SHIFT_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;
`ifdef SHIFT_STICKY_EN
                in_p.sticky = |in_data;
`endif
            end
        end
    end

    assign so_load = !so_vld || out_rdy;
    assign in_rdy  = s0_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld <= 1'b0;
            s0_q   <= '0;
        end else if (s0_load) begin
            s0_vld <= in_vld;
            if (in_vld) begin
                s0_q <= in_p;
            end
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        payload_t         src;
        payload_t         dst;
        logic [WIDTH-1:0] result;
`ifdef SHIFT_STICKY_EN
        logic             sticky_next;
`endif

        if (MID_REG != 0 && k == SPLIT) begin : g_from_mid
            assign src = g_mid.sm_q;
        end else if (k == 0) begin : g_from_s0
            assign src = s0_q;
        end else begin : g_from_prev
            assign src = g_lvl[k-1].dst;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .en          (src.amt[k]),
            .mode        (src.mode),
            .data        (src.data),
            .result      (result)
`ifdef SHIFT_STICKY_EN
            ,
            .sticky      (src.sticky),
            .sticky_next (sticky_next)
`endif
        );

        always_comb begin
            dst      = src;
            dst.data = result;
`ifdef SHIFT_STICKY_EN
            dst.sticky = sticky_next;
`endif
        end
    end

    if (MID_REG != 0) begin : g_mid
        payload_t sm_q;
        payload_t sm_d;
        logic     sm_vld;
        logic     sm_load;

        if (SPLIT == 0) begin : g_d_s0
            assign sm_d = s0_q;
        end else begin : g_d_lvl
            assign sm_d = g_lvl[SPLIT-1].dst;
        end

        assign sm_load = !sm_vld || so_load;
        assign s0_load = !s0_vld || sm_load;
        assign up_vld  = sm_vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                sm_vld <= 1'b0;
                sm_q   <= '0;
            end else if (sm_load) begin
                sm_vld <= s0_vld;
                if (s0_vld) begin
                    sm_q <= sm_d;
                end
            end
        end
    end else begin : g_direct
        assign s0_load = !s0_vld || so_load;
        assign up_vld  = s0_vld;
    end

    assign tail        = g_lvl[SHW-1].dst;
    assign unused_tail = ^{tail.amt, tail.mode};

`ifdef SHIFT_STICKY_EN
    logic so_sticky;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            so_vld  <= 1'b0;
            so_data <= '0;
            so_tag  <= '0;
`ifdef SHIFT_STICKY_EN
            so_sticky <= 1'b0;
`endif
        end else if (so_load) begin
            so_vld <= up_vld;
            if (up_vld) begin
                so_data <= tail.data;
                so_tag  <= tail.tag;
`ifdef SHIFT_STICKY_EN
                so_sticky <= tail.sticky;
`endif
            end
        end
    end

    assign out_vld  = so_vld;
    assign out_data = so_data;
    assign out_tag  = so_tag;
`ifdef SHIFT_STICKY_EN
    assign out_sticky = so_sticky;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - directed self-checking bench for barrel_shift_pipe (WIDTH=24 and WIDTH=32 MID_REG=1)
module tb_barrel_shift_pipe;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, in_rdy, out_vld, out_rdy;
    logic [23:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag, out_tag;

    logic        m_in_vld, m_in_rdy, m_out_vld, m_out_rdy;
    logic [31:0] m_in_data, m_out_data;
    logic [4:0]  m_in_shamt;
    logic [1:0]  m_in_mode;
    logic [3:0]  m_in_tag, m_out_tag;

`ifdef SHIFT_STICKY_EN
    logic        out_sticky, m_out_sticky, got_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    barrel_shift_pipe #(.WIDTH(24), .TAG_W(4), .MID_REG(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_tag  (out_tag)
`ifdef SHIFT_STICKY_EN
        ,
        .out_sticky (out_sticky)
`endif
    );

    barrel_shift_pipe #(.WIDTH(32), .TAG_W(4), .MID_REG(1)) dut_m (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (m_in_vld),
        .in_rdy   (m_in_rdy),
        .in_data  (m_in_data),
        .in_shamt (m_in_shamt),
        .in_mode  (m_in_mode),
        .in_tag   (m_in_tag),
        .out_vld  (m_out_vld),
        .out_rdy  (m_out_rdy),
        .out_data (m_out_data),
        .out_tag  (m_out_tag)
`ifdef SHIFT_STICKY_EN
        ,
        .out_sticky (m_out_sticky)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single operation with out_rdy high: result must show up exactly two cycles after acceptance.
    task automatic op24(input string name, input logic [1:0] mode, input logic [23:0] data,
                        input logic [4:0] sh, input logic [3:0] tag, input logic [23:0] exp);
        @(negedge clk);
        out_rdy  = 1'b1;
        in_vld   = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_shamt = sh;
        in_tag   = tag;
        #1;
        chk({name, " in_rdy"}, 64'(in_rdy), 64'd1);
        @(negedge clk);
        in_vld = 1'b0;
        chk({name, " early vld"}, 64'(out_vld), 64'd0);
        @(negedge clk);
        chk({name, " vld"}, 64'(out_vld), 64'd1);
        chk({name, " data"}, 64'(out_data), 64'(exp));
        chk({name, " tag"}, 64'(out_tag), 64'(tag));
`ifdef SHIFT_STICKY_EN
        got_sticky = out_sticky;
`endif
    endtask

    initial begin
        int sent, rcvd, cyc;
        logic acc;

        rst = 1'b1;
        in_vld = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0; out_rdy = 1'b1;
        m_in_vld = 1'b0; m_in_data = '0; m_in_shamt = '0; m_in_mode = '0; m_in_tag = '0; m_out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out_vld", 64'(out_vld), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_tag", 64'(out_tag), 64'd0);
        chk("reset in_rdy", 64'(in_rdy), 64'd1);
        chk("reset mid out_vld", 64'(m_out_vld), 64'd0);

        op24("sll 1 by 23",      SHIFT_SLL, 24'h000001, 5'd23, 4'd1, 24'h800000);
        op24("sra 800000 by 4",  SHIFT_SRA, 24'h800000, 5'd4,  4'd2, 24'hF80000);
        op24("rol 800001 by 1",  SHIFT_ROL, 24'h800001, 5'd1,  4'd3, 24'h000003);
        op24("srl abcdef by 8",  SHIFT_SRL, 24'hABCDEF, 5'd8,  4'd4, 24'h00ABCD);
        op24("sra 7fffff by 3",  SHIFT_SRA, 24'h7FFFFF, 5'd3,  4'd5, 24'h0FFFFF);
        op24("sll abcdef by 0",  SHIFT_SLL, 24'hABCDEF, 5'd0,  4'd6, 24'hABCDEF);
        op24("rol 123456 by 12", SHIFT_ROL, 24'h123456, 5'd12, 4'd7, 24'h456123);
        op24("srl ffffff by 31", SHIFT_SRL, 24'hFFFFFF, 5'd31, 4'd8, 24'h000000);
        op24("sra 800000 by 24", SHIFT_SRA, 24'h800000, 5'd24, 4'd9, 24'hFFFFFF);
        op24("sra 800000 by 31", SHIFT_SRA, 24'h800000, 5'd31, 4'd10, 24'hFFFFFF);
        op24("sll 1 by 24",      SHIFT_SLL, 24'h000001, 5'd24, 4'd11, 24'h000000);
        op24("rol 1 by 25",      SHIFT_ROL, 24'h000001, 5'd25, 4'd12, 24'h000002);

`ifdef SHIFT_STICKY_EN
        op24("sticky srl 3 by 1", SHIFT_SRL, 24'h000003, 5'd1, 4'd1, 24'h000001);
        chk("sticky srl 3 by 1 flag", 64'(got_sticky), 64'd1);
        op24("sticky srl 4 by 2", SHIFT_SRL, 24'h000004, 5'd2, 4'd2, 24'h000001);
        chk("sticky srl 4 by 2 flag", 64'(got_sticky), 64'd0);
        op24("sticky sll c00000 by 1", SHIFT_SLL, 24'hC00000, 5'd1, 4'd3, 24'h800000);
        chk("sticky sll c00000 by 1 flag", 64'(got_sticky), 64'd1);
`endif

        // Stream of 16 ops (SLL (i+1) by i, tag i) with a 5-cycle consumer stall.
        @(negedge clk);
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 16 && cyc < 100) begin
            out_rdy  = !(cyc >= 6 && cyc < 11);
            in_vld   = (sent < 16);
            in_mode  = SHIFT_SLL;
            in_data  = 24'(sent + 1);
            in_shamt = 5'(sent);
            in_tag   = 4'(sent);
            #1;
            if (cyc == 10) chk("stream in_rdy during stall", 64'(in_rdy), 64'd0);
            acc = in_vld && in_rdy;
            if (out_vld) begin
                chk("stream tag", 64'(out_tag), 64'(rcvd % 16));
                chk("stream data", 64'(out_data), 64'((rcvd + 1) << rcvd));
                if (out_rdy) rcvd++;
            end
            if (acc) sent++;
            cyc++;
            @(negedge clk);
        end
        chk("stream results received", 64'(rcvd), 64'd16);
        chk("stream ops accepted", 64'(sent), 64'd16);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stream no extra vld", 64'(out_vld), 64'd0);
        end

        // MID_REG=1, WIDTH=32: op i accepted in cycle i must appear in cycle i+3, back to back.
        @(negedge clk);
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 8 && cyc < 60) begin
            m_out_rdy  = 1'b1;
            m_in_vld   = (sent < 8);
            m_in_mode  = (sent == 0) ? SHIFT_SLL : SHIFT_SRL;
            m_in_data  = (sent == 0) ? 32'h00000001 : 32'h80000000;
            m_in_shamt = (sent == 0) ? 5'd31 : 5'(sent);
            m_in_tag   = 4'(sent);
            #1;
            if (m_in_vld) chk("mid in_rdy", 64'(m_in_rdy), 64'd1);
            if (m_out_vld) begin
                chk("mid result cycle", 64'(cyc), 64'(rcvd + 3));
                chk("mid tag", 64'(m_out_tag), 64'(rcvd));
                chk("mid data", 64'(m_out_data), 64'(32'h80000000 >> rcvd));
                rcvd++;
            end
            if (m_in_vld && m_in_rdy) sent++;
            cyc++;
            @(negedge clk);
        end
        chk("mid results received", 64'(rcvd), 64'd8);
        m_in_vld = 1'b0;

        // Reset with two operations in flight.
        out_rdy  = 1'b0;
        in_vld   = 1'b1;
        in_mode  = SHIFT_SLL;
        in_data  = 24'h000001;
        in_shamt = 5'd1;
        in_tag   = 4'd1;
        @(negedge clk);
        in_tag   = 4'd2;
        #1;
        chk("flight second accept", 64'(in_rdy), 64'd1);
        @(negedge clk);
        in_vld = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("rst flight out_vld", 64'(out_vld), 64'd0);
        chk("rst flight out_data", 64'(out_data), 64'd0);
        chk("rst flight in_rdy", 64'(in_rdy), 64'd1);
        rst     = 1'b0;
        out_rdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst no stale result", 64'(out_vld), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

endmodule
